sccb_cam_arbiter: RTL
=====================

SCCB_CAM_ARBITER -- requirements
Module: sccb_cam_arbiter

Interface
REQ-001 Parameters SHALL be: TIMEOUT_CYCLES, 20000, WAIT-state cycle limit before abort (1 ms at 20 MHz HCLK).
REQ-002 HCLK  input  1  single clock; all logic on its rising edge.
REQ-003 hwRst  input  1  asynchronous, active-high reset.
REQ-004 rq0_valid / rq1_valid  input  1  requester N holds a pending SCCB command.
REQ-005 rq0_ready / rq1_ready  output  1  one-cycle accept pulse to requester N.
REQ-006 rq0_wr / rq1_wr  input  1  1=write, 0=read.
REQ-007 rq0_dev / rq1_dev  input  8  SCCB device address.
REQ-008 rq0_reg / rq1_reg  input  16  camera register address.
REQ-009 rq0_wdata / rq1_wdata  input  8  write data.
REQ-010 rq0_done / rq1_done  output  1  one-cycle completion pulse to requester N.
REQ-011 rq0_rdata / rq1_rdata  output  8  read data, valid with done.
REQ-012 rq0_err / rq1_err  output  1  error flag, valid with done.
REQ-013 m_valid  output  1  command to shared SCCB master valid.
REQ-014 m_ready  input  1  master accepts command.
REQ-015 m_wr, m_dev[7:0], m_reg[15:0], m_wdata[7:0]  output  -  held command fields.
REQ-016 m_done  input  1  master transaction finished.
REQ-017 m_rdata  input  8  master read data, valid with m_done.
REQ-018 m_nack  input  1  master saw NACK, valid with m_done.
REQ-019 m_abort  output  1  one-cycle abort pulse to master.
REQ-020 busy  output  1  high whenever state is not IDLE.
REQ-021 grant_id  output  1  index of requester currently owning the master.

Function
REQ-022 FSM states SHALL be IDLE, ISSUE, WAIT, RESP.
REQ-023 IDLE, one valid: grant that requester. Both valid: grant the one not granted last (round-robin pointer). Latch its command fields. Pulse its rqN_ready for one cycle. Go to ISSUE next cycle.
REQ-024 ISSUE: m_valid=1 with latched fields held stable. On m_valid&m_ready, go to WAIT next cycle.
REQ-025 WAIT: on m_done, capture m_rdata and m_nack, then go to RESP.
REQ-026 m_done in IDLE, ISSUE or RESP SHALL be ignored.
REQ-027 RESP: pulse rqN_done for grant_id for exactly one cycle, with rdata and err (err = captured nack). Update pointer to grant_id. Return to IDLE.
REQ-028 Latency: request in IDLE -> m_valid in 1 cycle; m_done -> rqN_done in 1 cycle; a new grant is possible no earlier than the cycle after RESP.
REQ-029 rqN_valid changes after acceptance SHALL NOT affect the in-flight command.
REQ-030 rqN_rdata and rqN_err SHALL hold their last values between done pulses; the non-granted requester's outputs are unchanged.

Reset
REQ-031 On hwRst: state=IDLE, pointer=1 (rq0 wins the first tie), grant_id=0, and all outputs 0 including m_* fields, rdata and err.
REQ-032 Reset mid-transaction SHALL abandon the transaction with no done pulse; after reset is released, the block SHALL wait in IDLE.

Configuration
REQ-033 With macro SCCB_ARB_TIMEOUT_EN defined:
- a 16-bit counter clears on entering WAIT and increments each WAIT cycle;
- at count == TIMEOUT_CYCLES without m_done: pulse m_abort, go to RESP with err=1 and rdata=0x00;
- if m_done and timeout occur in the same cycle, m_done wins.
REQ-034 Without SCCB_ARB_TIMEOUT_EN: no counter, WAIT has no limit, m_abort is tied 0, and err = nack only.

Verification
REQ-035 rq0 write dev=0x78 reg=0x3008 data=0x82 alone -> rq0_ready pulse, m_valid next cycle with those fields, m_done -> rq0_done with err=0.
REQ-036 rq0 and rq1 valid in the same cycle after reset -> rq0 granted first, rq1 second; a third tie -> rq0.
REQ-037 rq1 read with m_rdata=0x56, m_nack=1 -> rq1_done, rq1_rdata=0x56, rq1_err=1; rq0 outputs unchanged.
REQ-038 Macro on, TIMEOUT_CYCLES=8, no m_done -> m_abort and rqN_done with err=1 exactly 8 cycles after entering WAIT; m_done on cycle 8 -> err=nack.
REQ-039 hwRst asserted during WAIT -> all outputs 0 immediately, no done pulse; a fresh request then completes normally.
REQ-040 m_ready held low for 5 cycles -> m_valid and fields stable throughout; no second accept pulse.

Source files
------------

// File: rtl/sccb_cam_arbiter.sv
// Two-requester round-robin arbiter in front of one shared SCCB master.
// Optional WAIT-state timeout/abort is enabled with `define SCCB_ARB_TIMEOUT_EN.
module sccb_cam_arbiter #(
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic        HCLK,
  input  logic        hwRst,
  input  logic        rq0_valid,
  output logic        rq0_ready,
  input  logic        rq0_wr,
  input  logic [7:0]  rq0_dev,
  input  logic [15:0] rq0_reg,
  input  logic [7:0]  rq0_wdata,
  output logic        rq0_done,
  output logic [7:0]  rq0_rdata,
  output logic        rq0_err,
  input  logic        rq1_valid,
  output logic        rq1_ready,
  input  logic        rq1_wr,
  input  logic [7:0]  rq1_dev,
  input  logic [15:0] rq1_reg,
  input  logic [7:0]  rq1_wdata,
  output logic        rq1_done,
  output logic [7:0]  rq1_rdata,
  output logic        rq1_err,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_wr,
  output logic [7:0]  m_dev,
  output logic [15:0] m_reg,
  output logic [7:0]  m_wdata,
  input  logic        m_done,
  input  logic [7:0]  m_rdata,
  input  logic        m_nack,
  output logic        m_abort,
  output logic        busy,
  output logic        grant_id
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  // The counter is 16 bits wide, so the limit must fit in it.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("sccb_cam_arbiter: TIMEOUT_CYCLES must be in 1..65535");
  end

  logic [1:0] state;
  logic       rr_ptr;
  logic       any_valid;
  logic       pick;
  logic       accept;
  logic       timeout;
  logic       resp_en;
  logic [7:0] resp_rdata;
  logic       resp_err;

  // rr_ptr holds the last requester served; on a tie the other one wins.
  always_comb begin
    any_valid = rq0_valid | rq1_valid;
    pick      = (rq0_valid & rq1_valid) ? ~rr_ptr : rq1_valid;
    accept    = (state == ST_IDLE) & any_valid & ~hwRst;
  end

  assign rq0_ready = accept & ~pick;
  assign rq1_ready = accept & pick;
  assign m_valid   = (state == ST_ISSUE);
  assign busy      = (state != ST_IDLE);
  assign rq0_done  = (state == ST_RESP) & ~grant_id;
  assign rq1_done  = (state == ST_RESP) & grant_id;

`ifdef SCCB_ARB_TIMEOUT_EN
  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES);
  logic [15:0] wait_cnt;

  always_ff @(posedge HCLK or posedge hwRst) begin
    if (hwRst) begin
      wait_cnt <= '0;
    end else if (state != ST_WAIT) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + 16'd1;
    end
  end

  // A completion arriving in the limit cycle takes priority over the abort.
  assign timeout = (state == ST_WAIT) & (wait_cnt == TO_LIMIT) & ~m_done;
`else
  assign timeout = 1'b0;
`endif

  assign m_abort = timeout;

  always_comb begin
    resp_en    = (state == ST_WAIT) & (m_done | timeout);
    resp_rdata = m_done ? m_rdata : 8'h00;
    resp_err   = m_done ? m_nack : 1'b1;
  end

  always_ff @(posedge HCLK or posedge hwRst) begin
    if (hwRst) begin
      state    <= ST_IDLE;
      rr_ptr   <= 1'b1;
      grant_id <= 1'b0;
      m_wr     <= 1'b0;
      m_dev    <= '0;
      m_reg    <= '0;
      m_wdata  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_valid) begin
            grant_id <= pick;
            m_wr     <= pick ? rq1_wr    : rq0_wr;
            m_dev    <= pick ? rq1_dev   : rq0_dev;
            m_reg    <= pick ? rq1_reg   : rq0_reg;
            m_wdata  <= pick ? rq1_wdata : rq0_wdata;
            state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (m_ready) begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (m_done || timeout) begin
            state <= ST_RESP;
          end
        end
        ST_RESP: begin
          rr_ptr <= grant_id;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Response registers are written on the WAIT exit so they are valid with done.
  always_ff @(posedge HCLK or posedge hwRst) begin
    if (hwRst) begin
      rq0_rdata <= '0;
      rq0_err   <= 1'b0;
      rq1_rdata <= '0;
      rq1_err   <= 1'b0;
    end else if (resp_en) begin
      if (grant_id) begin
        rq1_rdata <= resp_rdata;
        rq1_err   <= resp_err;
      end else begin
        rq0_rdata <= resp_rdata;
        rq0_err   <= resp_err;
      end
    end
  end

endmodule
